// File: rtl/fifo_rr_drain_pkg.sv
// Shared constants, FSM encoding and burst-length helper for the
// round-robin FIFO drain family.
package fifo_rr_drain_pkg;

    localparam int MAX_PORTS = 8;
    localparam int SRC_W     = 3;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    // The comparison runs at full width so a large word count is never truncated before the clamp.
    function automatic int unsigned burst_len(input int unsigned words, input int unsigned limit);
        return (words > limit) ? limit : words;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_if.sv
// FIFO read-side bundle plus the tagged output stream of fifo_rr_drain.
interface fifo_rr_drain_if #(
    parameter int N_PORTS = 4,
    parameter int WW      = 10
);
    import fifo_rr_drain_pkg::*;

    logic [N_PORTS-1:0]    i_fifo_empty;
    logic [N_PORTS*WW-1:0] i_fifo_words;
    logic [N_PORTS*32-1:0] i_fifo_data;
    logic [N_PORTS-1:0]    o_fifo_rd_en;
    logic [N_PORTS-1:0]    i_port_en;
    logic [31:0]           o_out_data;
    logic                  o_out_valid;
    logic                  i_out_ready;
    logic [SRC_W-1:0]      o_out_src;
    logic                  o_out_last;
    logic                  o_busy;

    modport master (
        output i_fifo_empty, i_fifo_words, i_fifo_data, i_port_en, i_out_ready,
        input  o_fifo_rd_en, o_out_data, o_out_valid, o_out_src, o_out_last, o_busy
    );

    modport slave (
        input  i_fifo_empty, i_fifo_words, i_fifo_data, i_port_en, i_out_ready,
        output o_fifo_rd_en, o_out_data, o_out_valid, o_out_src, o_out_last, o_busy
    );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational cyclic priority encoder: first set bit of req at or after ptr.
module fifo_rr_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Walk farthest-to-nearest so the candidate closest to ptr is the last write.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin burst reader: drains the granted FIFO into one tagged,
// backpressured 32-bit output register.
module fifo_rr_drain
    import fifo_rr_drain_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int BURST_MAX = 16,
    parameter int WW        = 10
) (
    input logic            clk,
    input logic            rst,
    fifo_rr_drain_if.slave bus
);

    localparam int IDX_W = $clog2(N_PORTS);
    localparam int REM_W = $clog2(BURST_MAX + 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant;
    logic [REM_W-1:0]   rem;

    logic [N_PORTS-1:0] cand;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [WW-1:0]      pick_words;
    logic               rd_fire;
    logic               consume;

    always_comb begin
        cand = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand[k] = bus.i_port_en[k] & ~bus.i_fifo_empty[k] & (bus.i_fifo_words[k*WW +: WW] != '0);
        end
    end

    fifo_rr_pick #(.N(N_PORTS)) u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_words = bus.i_fifo_words[int'(pick_idx)*WW +: WW];

    // A read may only happen when the output register is empty or being drained this cycle.
    assign rd_fire = (state == ST_BURST) && (rem != '0) && (!bus.o_out_valid || bus.i_out_ready);
    assign consume = bus.o_out_valid & bus.i_out_ready;
    assign bus.o_busy = (state == ST_BURST);

    always_comb begin
        bus.o_fifo_rd_en = '0;
        if (rd_fire) begin
            bus.o_fifo_rd_en[grant] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            rem             <= '0;
            bus.o_out_valid <= 1'b0;
            bus.o_out_data  <= '0;
            bus.o_out_src   <= '0;
            bus.o_out_last  <= 1'b0;
        end else begin
            if (rd_fire) begin
                bus.o_out_data  <= bus.i_fifo_data[int'(grant)*32 +: 32];
                bus.o_out_src   <= SRC_W'(grant);
                bus.o_out_last  <= (rem == REM_W'(1));
                bus.o_out_valid <= 1'b1;
            end else if (consume) begin
                bus.o_out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        rem   <= REM_W'(burst_len(32'(pick_words), BURST_MAX));
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (rd_fire) begin
                        rem <= rem - 1'b1;
                        if (rem == REM_W'(1)) begin
                            rr_ptr <= (grant == IDX_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Scoreboard bench for fifo_rr_drain: queue-modelled FIFOs feed the DUT and
// every consumed word is compared against the expected burst sequence.
module tb_fifo_rr_drain;
    import fifo_rr_drain_pkg::*;

    localparam int N  = 4;
    localparam int WW = 10;
    localparam int BM = 16;

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rr_drain_if #(.N_PORTS(N), .WW(WW)) bus ();

    fifo_rr_drain #(.N_PORTS(N), .BURST_MAX(BM), .WW(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    logic [31:0] fq[N][$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [N-1:0] rd_snap = '0;
    logic        stalled_q = 1'b0;
    logic [31:0] data_q;
    logic [2:0]  src_q;
    logic        last_q;
    event        refresh_ev;

    function automatic logic [31:0] mk(input int k, input int s);
        return 32'hD000_0000 | (32'(k) << 16) | 32'(s);
    endfunction

    // Single writer of the FIFO-side inputs.
    always @(refresh_ev) begin
        for (int k = 0; k < N; k++) begin
            bus.i_fifo_empty[k]          = (fq[k].size() == 0);
            bus.i_fifo_words[k*WW +: WW] = WW'(fq[k].size());
            bus.i_fifo_data[k*32 +: 32]  = (fq[k].size() != 0) ? fq[k][0] : 32'h0;
        end
    end

    // FIFO read pointers advance on every edge that saw rd_en, reset or not.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (rd_snap[k] && fq[k].size() != 0) void'(fq[k].pop_front());
        end
        -> refresh_ev;
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        rd_snap = bus.o_fifo_rd_en;
        n_checks++;
        if (!$onehot0(rd_snap)) begin
            n_fail++;
            $display("FAIL rd_en_onehot: got %b, required one-hot or zero", rd_snap);
        end
        for (int k = 0; k < N; k++) begin
            if (rd_snap[k]) begin
                n_checks++;
                if (fq[k].size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_empty: port %0d read while its FIFO holds 0 words", k);
                end
            end
        end
        if (bus.o_out_valid === 1'b1 && bus.i_out_ready === 1'b0) begin
            n_checks++;
            if (rd_snap !== '0) begin
                n_fail++;
                $display("FAIL rd_while_stalled: got rd_en %b, required 0", rd_snap);
            end
        end
        if (stalled_q) begin
            n_checks++;
            if (bus.o_out_valid !== 1'b1 || bus.o_out_data !== data_q ||
                bus.o_out_src !== src_q || bus.o_out_last !== last_q) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b d=%h s=%0d l=%b, required v=1 d=%h s=%0d l=%b",
                         bus.o_out_valid, bus.o_out_data, bus.o_out_src, bus.o_out_last,
                         data_q, src_q, last_q);
            end
        end
        if (bus.o_out_valid === 1'b1 && bus.i_out_ready === 1'b1) begin
            a.src  = bus.o_out_src;
            a.data = bus.o_out_data;
            a.last = bus.o_out_last;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got src=%0d data=%h last=%b, required no word",
                         a.src, a.data, a.last);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard: got src=%0d data=%h last=%b, required src=%0d data=%h last=%b",
                             a.src, a.data, a.last, e.src, e.data, e.last);
                end
            end
        end
        stalled_q = (bus.o_out_valid === 1'b1) && (bus.i_out_ready === 1'b0) && !rst;
        data_q    = bus.o_out_data;
        src_q     = bus.o_out_src;
        last_q    = bus.o_out_last;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic add_fifo(input int k, input int n, input int start);
        for (int i = 0; i < n; i++) fq[k].push_back(mk(k, start + i));
        -> refresh_ev;
    endtask

    task automatic expect_burst(input int k, input int n, input int start);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.src  = 3'(k);
            e.data = mk(k, start + i);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) fq[k].delete();
        sb.delete();
        bus.i_port_en   = '1;
        bus.i_out_ready = 1'b1;
        -> refresh_ev;
        step();
        step();
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int c = 0;
        while (sb.size() != 0 && c < max_cycles) begin
            step();
            c++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d words outstanding after %0d cycles, required 0", name, sb.size(), c);
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (bus.o_fifo_rd_en !== '0) begin n_fail++; $display("FAIL %s_rd_en: got %b, required 0", name, bus.o_fifo_rd_en); end
        n_checks++;
        if (bus.o_out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid: got %b, required 0", name, bus.o_out_valid); end
        n_checks++;
        if (bus.o_out_data !== 32'h0) begin n_fail++; $display("FAIL %s_data: got %h, required 0", name, bus.o_out_data); end
        n_checks++;
        if (bus.o_out_src !== 3'd0) begin n_fail++; $display("FAIL %s_src: got %0d, required 0", name, bus.o_out_src); end
        n_checks++;
        if (bus.o_out_last !== 1'b0) begin n_fail++; $display("FAIL %s_last: got %b, required 0", name, bus.o_out_last); end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b, required 0", name, bus.o_busy); end
    endtask

    task automatic test_reset();
        do_reset();
        check_outputs_zero("reset");
    endtask

    task automatic test_single_port();
        do_reset();
        add_fifo(2, 5, 0);
        expect_burst(2, 5, 0);
        rst = 1'b0;
        n_checks++;
        if (bus.o_fifo_rd_en !== 4'b0000) begin n_fail++; $display("FAIL grant_idle: got %b, required 0000", bus.o_fifo_rd_en); end
        step();
        n_checks++;
        if (bus.o_fifo_rd_en !== 4'b0100) begin n_fail++; $display("FAIL first_rd_en: got %b, required 0100", bus.o_fifo_rd_en); end
        step();
        n_checks++;
        if (bus.o_out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b, required 1", bus.o_out_valid); end
        wait_drain(20, "single");
        step();
        n_checks++;
        if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b, required 0", bus.o_busy); end
        // rr_ptr is now 3, so port 3 wins over port 0.
        add_fifo(0, 1, 0);
        add_fifo(3, 1, 0);
        expect_burst(3, 1, 0);
        expect_burst(0, 1, 0);
        wait_drain(20, "rr_ptr");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < N; k++) add_fifo(k, 20, 0);
        for (int k = 0; k < N; k++) expect_burst(k, BM, 0);
        for (int k = 0; k < N; k++) expect_burst(k, 20 - BM, BM);
        rst = 1'b0;
        wait_drain(200, "all_ports");
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        add_fifo(1, 8, 0);
        expect_burst(1, 8, 0);
        rst = 1'b0;
        while (sb.size() != 0 && c < 100) begin
            bus.i_out_ready = ~bus.i_out_ready;
            step();
            c++;
        end
        bus.i_out_ready = 1'b1;
        wait_drain(5, "backpressure");
    endtask

    task automatic test_port_mask();
        do_reset();
        bus.i_port_en = 4'b1011;
        for (int k = 0; k < N; k++) add_fifo(k, 3, 0);
        expect_burst(0, 3, 0);
        expect_burst(1, 3, 0);
        expect_burst(3, 3, 0);
        rst = 1'b0;
        wait_drain(60, "mask");
        repeat (5) step();
        n_checks++;
        if (fq[2].size() != 3) begin n_fail++; $display("FAIL mask_port2: got %0d words left, required 3", fq[2].size()); end

        do_reset();
        add_fifo(0, 6, 0);
        expect_burst(0, 6, 0);
        rst = 1'b0;
        step();
        bus.i_port_en = 4'b1110;
        wait_drain(30, "en_clear");
        bus.i_port_en = '1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   c = 0;
        do_reset();
        add_fifo(1, 1, 0);
        expect_burst(1, 1, 0);
        rst = 1'b0;
        wait_drain(20, "pre_burst");
        add_fifo(0, 8, 0);
        for (int i = 0; i < 2; i++) begin
            e.src = 3'd0; e.data = mk(0, i); e.last = 1'b0;
            sb.push_back(e);
        end
        while (!(fq[0].size() == 6 && bus.o_fifo_rd_en[0] === 1'b1) && c < 20) begin
            step();
            c++;
        end
        n_checks++;
        if (c >= 20) begin n_fail++; $display("FAIL third_read_timeout: waited %0d cycles, required third read", c); end
        rst = 1'b1;
        step();
        check_outputs_zero("mid_reset");
        n_checks++;
        if (fq[0].size() != 5) begin n_fail++; $display("FAIL mid_reset_drop: got %0d words left, required 5", fq[0].size()); end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL mid_reset_words: got %0d outstanding, required 0", sb.size()); sb.delete(); end
        // rr_ptr was 2 before reset: port 0 first proves it returned to 0.
        add_fifo(3, 2, 0);
        expect_burst(0, 5, 3);
        expect_burst(3, 2, 0);
        rst = 1'b0;
        wait_drain(40, "restart");
    endtask

    task automatic test_growth();
        do_reset();
        add_fifo(0, 3, 0);
        expect_burst(0, 3, 0);
        expect_burst(0, 7, 3);
        rst = 1'b0;
        step();
        n_checks++;
        if (bus.o_fifo_rd_en !== 4'b0001) begin n_fail++; $display("FAIL growth_grant: got %b, required 0001", bus.o_fifo_rd_en); end
        add_fifo(0, 7, 3);
        wait_drain(40, "growth");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_port();
        test_back_to_back();
        test_backpressure();
        test_port_mask();
        test_reset_mid();
        test_growth();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain.md
# fifo_rr_drain

Round-robin read scheduler that drains up to N_PORTS mesochronous FIFO read sides into one 32-bit output stream. It grants one non-empty, enabled FIFO at a time and drives that FIFO's read enable for a burst of min(available words, BURST_MAX) words. Each output word is tagged with its source port and with a last-of-burst flag. It sits on the read clock domain between the per-link input FIFOs and a single downstream consumer, such as the crossbar or DMA engine.

## Interface
- N_PORTS, 4: number of FIFOs served (2..8).
- BURST_MAX, 16: maximum words per grant (1..512).
- WW, 10: width of each FIFO's word-count input.
- clk  in  1: the only clock, the FIFOs' read clock.
- rst  in  1: synchronous, active-high reset.
- i_fifo_empty  in  N_PORTS: per-FIFO empty flag.
- i_fifo_words  in  N_PORTS*WW: per-FIFO readable word count. Port k is at bits [k*WW +: WW].
- i_fifo_data  in  N_PORTS*32: per-FIFO head word. Valid whenever that FIFO is not empty.
- o_fifo_rd_en  out  N_PORTS: per-FIFO read advance. One-hot or zero.
- i_port_en  in  N_PORTS: port enable mask. A disabled port is never granted.
- o_out_data  out  32: output word.
- o_out_valid  out  1: o_out_data is valid.
- i_out_ready  in  1: the consumer accepts the word this cycle.
- o_out_src  out  3: source port index of o_out_data.
- o_out_last  out  1: o_out_data is the last word of its burst.
- o_busy  out  1: a burst is in progress (state BURST).

## Operation
- FSM states:
  - IDLE: no port is granted.
  - BURST: port g is granted and rem words remain to be read from it.
- Candidate set: k with i_port_en[k] and ~i_fifo_empty[k] and words[k] != 0.
- IDLE transitions:
  - If the candidate set is non-empty, pick the first candidate searching cyclically from rr_ptr. Latch g and set rem = min(words[g], BURST_MAX), then go to BURST.
  - Otherwise stay in IDLE.
- BURST, read rule: o_fifo_rd_en[g] = (rem != 0) & (~o_out_valid | i_out_ready). No other bit is ever set.
- BURST, on each read:
  - Load the output register: o_out_data = i_fifo_data[g], o_out_src = g, o_out_last = (rem == 1), o_out_valid = 1.
  - Decrement rem.
- BURST end: after the read with rem == 1, set rr_ptr = (g+1) mod N_PORTS and return to IDLE in the same cycle.
- Output register:
  - A word is consumed when o_out_valid & i_out_ready.
  - If consumed with no new read, clear o_out_valid.
  - Hold o_out_data, o_out_src and o_out_last stable while o_out_valid & ~i_out_ready.
- The latched burst length is a guarantee, not an estimate. The FIFO word count only grows from the write side while it is granted, so every read in the burst hits a non-empty FIFO. The block never reads an empty FIFO.
- Clearing i_port_en[g] mid-burst does not abort the burst. The mask is sampled only in IDLE.
- o_out_src width is fixed at 3 bits. Upper bits are 0 when N_PORTS < 8.

## Timing
- Reset values:
  - State IDLE, rr_ptr = 0, rem = 0.
  - o_fifo_rd_en = 0, o_out_valid = 0, o_out_data = 0, o_out_src = 0, o_out_last = 0, o_busy = 0.
- Grant latency: a candidate visible in IDLE at cycle t gives its first rd_en at t+1. The first word is valid at o_out_* at t+2.
- Throughput: with i_out_ready held high, one word per cycle within a burst. One idle cycle (IDLE) between bursts.
- Backpressure: o_fifo_rd_en depends combinationally on i_out_ready. No other input reaches an output combinationally.
- A read and a consume in the same cycle are a pass-through: o_out_valid stays 1 and the data is updated.
- rst asserted mid-burst: all state returns to reset values on the next edge. Words already read are dropped, and the FIFO pointers are not rewound.
- BURST_MAX == 1: every word carries o_out_last = 1, and ports alternate each grant.

## Structure
- The constants for the maximum port count (8) and the source-tag width (3) go in the shared FORMIC defines include used by the FIFO family.
- Sub-module fifo_rr_pick is combinational: it takes the candidate mask and rr_ptr and returns a valid flag and the granted index as a cyclic priority encoder. It is reusable by other round-robin schedulers.
- Burst length clamp: width clog2(BURST_MAX+1). words[g] is compared against BURST_MAX before truncation.

## Test plan
- Reset, then port 2 only with words = 5 and ready high:
  - First rd_en[2] two cycles after reset release.
  - 5 words out with src = 2, last on the 5th word.
  - Return to IDLE and rr_ptr = 3.
- All 4 ports with 20 words each, BURST_MAX = 16:
  - Grant order 0,1,2,3, with 16 words each and last on the 16th word.
  - Then 0,1,2,3 again with 4 words each.
- Port 1 with 8 words, i_out_ready toggling 1010…:
  - All 8 words delivered in order with no loss or duplication.
  - Output stable while stalled, and rd_en never asserted while valid & ~ready.
- i_port_en = 4'b1011 with all ports non-empty: port 2 is never granted. Clearing en[g] mid-burst still completes the burst.
- rst pulsed at the 3rd word of an 8-word burst: all outputs return to 0 next cycle, and rr_ptr = 0 on restart.
- Port 0 grows from 3 to 10 words during its burst: the burst is exactly 3 words. The remaining 7 are served on a later grant.
